// File: rtl/qos_fc_ctrl_if.sv
// Bundle of threshold, occupancy, overflow and status signals between the QoS
// datapath and its flow-control supervisor. The master side (datapath or bench)
// drives the levels and counts. The slave side (qos_fc_ctrl) returns pause/status.
interface qos_fc_ctrl_if #(
    parameter int MW = 4,
    parameter int VW = 16,
    parameter int DW = 4
);
    logic                init;
    logic [MW-1:0]       UmbralesMFs_HIGH;
    logic [MW-1:0]       UmbralesMFs_LOW;
    logic [2*VW-1:0]     UmbralesVCs_HIGH;
    logic [2*VW-1:0]     UmbralesVCs_LOW;
    logic [2*DW-1:0]     UmbralesDs_HIGH;
    logic [2*DW-1:0]     UmbralesDs_LOW;
    logic [MW-1:0]       Main_cnt;
    logic [VW-1:0]       VC0_cnt;
    logic [VW-1:0]       VC1_cnt;
    logic [DW-1:0]       D0_cnt;
    logic [DW-1:0]       D1_cnt;
    logic [4:0]          fifo_ovf;
    logic [4:0]          pause;
    logic                init_out;
    logic                idle_out;
    logic                active_out;
    logic                error_out;
    logic [4:0]          error_full;

    modport master (
        output init, UmbralesMFs_HIGH, UmbralesMFs_LOW, UmbralesVCs_HIGH,
               UmbralesVCs_LOW, UmbralesDs_HIGH, UmbralesDs_LOW,
               Main_cnt, VC0_cnt, VC1_cnt, D0_cnt, D1_cnt, fifo_ovf,
        input  pause, init_out, idle_out, active_out, error_out, error_full
    );

    modport slave (
        input  init, UmbralesMFs_HIGH, UmbralesMFs_LOW, UmbralesVCs_HIGH,
               UmbralesVCs_LOW, UmbralesDs_HIGH, UmbralesDs_LOW,
               Main_cnt, VC0_cnt, VC1_cnt, D0_cnt, D1_cnt, fifo_ovf,
        output pause, init_out, idle_out, active_out, error_out, error_full
    );
endinterface

// File: rtl/qos_fc_ctrl.sv
// Supervisory FSM for the QoS datapath: latches thresholds in INIT, drives hysteretic per-FIFO pause.
// Latency: every output is a flop, so input changes show up one rising edge later.
// Backpressure: pause[i] asserts at cnt>=HIGH and releases at cnt<=LOW. Overflows latch sticky error flags.
module qos_fc_ctrl #(
    parameter int MW = 4,
    parameter int VW = 16,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    qos_fc_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    state_e          state_q,      state_d;
    logic [MW-1:0]   mf_hi_q,      mf_hi_d;
    logic [MW-1:0]   mf_lo_q,      mf_lo_d;
    logic [2*VW-1:0] vc_hi_q,      vc_hi_d;
    logic [2*VW-1:0] vc_lo_q,      vc_lo_d;
    logic [2*DW-1:0] d_hi_q,       d_hi_d;
    logic [2*DW-1:0] d_lo_q,       d_lo_d;
    logic [4:0]      pause_q,      pause_d;
    logic [4:0]      err_full_q,   err_full_d;
    logic            init_out_q,   init_out_d;
    logic            idle_out_q,   idle_out_d;
    logic            active_out_q, active_out_d;
    logic            error_out_q,  error_out_d;

    logic            all_empty;

    // Hysteresis for one FIFO: reaching HIGH sets (and wins), falling to LOW clears, else hold.
    function automatic logic hyst(input logic        cur,
                                  input logic [31:0] cnt,
                                  input logic [31:0] hi,
                                  input logic [31:0] lo);
        logic r;
        r = cur;
        if (cnt >= hi) begin
            r = 1'b1;
        end else if (cnt <= lo) begin
            r = 1'b0;
        end
        return r;
    endfunction

    // Datapath is drained only when every FIFO reports zero occupancy.
    always_comb begin
        all_empty = (bus.Main_cnt == '0) && (bus.VC0_cnt == '0) && (bus.VC1_cnt == '0)
                 && (bus.D0_cnt == '0) && (bus.D1_cnt == '0);
    end

    // Next-state, threshold capture, pause hysteresis and sticky overflow tracking.
    always_comb begin
        state_d    = state_q;
        mf_hi_d    = mf_hi_q;
        mf_lo_d    = mf_lo_q;
        vc_hi_d    = vc_hi_q;
        vc_lo_d    = vc_lo_q;
        d_hi_d     = d_hi_q;
        d_lo_d     = d_lo_q;
        pause_d    = pause_q;
        err_full_d = err_full_q;

        if (bus.init) begin
            // init dominates everything, including an overflow on the same edge.
            state_d    = ST_INIT;
            mf_hi_d    = bus.UmbralesMFs_HIGH;
            mf_lo_d    = bus.UmbralesMFs_LOW;
            vc_hi_d    = bus.UmbralesVCs_HIGH;
            vc_lo_d    = bus.UmbralesVCs_LOW;
            d_hi_d     = bus.UmbralesDs_HIGH;
            d_lo_d     = bus.UmbralesDs_LOW;
            pause_d    = '0;
            err_full_d = '0;
        end else begin
            err_full_d = err_full_q | bus.fifo_ovf;

            // The INIT window keeps following the threshold inputs until it is left.
            if (state_q == ST_INIT) begin
                mf_hi_d = bus.UmbralesMFs_HIGH;
                mf_lo_d = bus.UmbralesMFs_LOW;
                vc_hi_d = bus.UmbralesVCs_HIGH;
                vc_lo_d = bus.UmbralesVCs_LOW;
                d_hi_d  = bus.UmbralesDs_HIGH;
                d_lo_d  = bus.UmbralesDs_LOW;
            end

            // Pause only evaluates against thresholds that were already frozen.
            if ((state_q == ST_RESET) || (state_q == ST_INIT)) begin
                pause_d = '0;
            end else begin
                pause_d[0] = hyst(pause_q[0], 32'(bus.Main_cnt), 32'(mf_hi_q), 32'(mf_lo_q));
                pause_d[1] = hyst(pause_q[1], 32'(bus.VC0_cnt),
                                  32'(vc_hi_q[VW-1:0]), 32'(vc_lo_q[VW-1:0]));
                pause_d[2] = hyst(pause_q[2], 32'(bus.VC1_cnt),
                                  32'(vc_hi_q[2*VW-1:VW]), 32'(vc_lo_q[2*VW-1:VW]));
                pause_d[3] = hyst(pause_q[3], 32'(bus.D0_cnt),
                                  32'(d_hi_q[DW-1:0]), 32'(d_lo_q[DW-1:0]));
                pause_d[4] = hyst(pause_q[4], 32'(bus.D1_cnt),
                                  32'(d_hi_q[2*DW-1:DW]), 32'(d_lo_q[2*DW-1:DW]));
            end

            if (bus.fifo_ovf != 5'b0) begin
                state_d = ST_ERROR;
            end else begin
                case (state_q)
                    ST_RESET:  state_d = ST_INIT;
                    ST_INIT:   state_d = all_empty ? ST_IDLE : ST_ACTIVE;
                    ST_IDLE:   state_d = all_empty ? ST_IDLE : ST_ACTIVE;
                    ST_ACTIVE: state_d = all_empty ? ST_IDLE : ST_ACTIVE;
                    ST_ERROR:  state_d = ST_ERROR;
                    default:   state_d = ST_RESET;
                endcase
            end
        end

        init_out_d   = (state_d == ST_INIT);
        idle_out_d   = (state_d == ST_IDLE);
        active_out_d = (state_d == ST_ACTIVE);
        error_out_d  = (state_d == ST_ERROR);
    end

    // State, threshold and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RESET;
            mf_hi_q      <= '0;
            mf_lo_q      <= '0;
            vc_hi_q      <= '0;
            vc_lo_q      <= '0;
            d_hi_q       <= '0;
            d_lo_q       <= '0;
            pause_q      <= '0;
            err_full_q   <= '0;
            init_out_q   <= 1'b0;
            idle_out_q   <= 1'b0;
            active_out_q <= 1'b0;
            error_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mf_hi_q      <= mf_hi_d;
            mf_lo_q      <= mf_lo_d;
            vc_hi_q      <= vc_hi_d;
            vc_lo_q      <= vc_lo_d;
            d_hi_q       <= d_hi_d;
            d_lo_q       <= d_lo_d;
            pause_q      <= pause_d;
            err_full_q   <= err_full_d;
            init_out_q   <= init_out_d;
            idle_out_q   <= idle_out_d;
            active_out_q <= active_out_d;
            error_out_q  <= error_out_d;
        end
    end

    assign bus.pause      = pause_q;
    assign bus.error_full = err_full_q;
    assign bus.init_out   = init_out_q;
    assign bus.idle_out   = idle_out_q;
    assign bus.active_out = active_out_q;
    assign bus.error_out  = error_out_q;

endmodule

// File: tb/tb_qos_fc_ctrl.sv
// Bench for qos_fc_ctrl: directed sequences with constant expectations, then a long
// randomized run compared every cycle against a behavioural model of the rules.
module tb_qos_fc_ctrl;
    localparam int MW = 4;
    localparam int VW = 16;
    localparam int DW = 4;

    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_INIT = 4'b0001;
    localparam logic [3:0] S_IDLE = 4'b0010;
    localparam logic [3:0] S_ACT  = 4'b0100;
    localparam logic [3:0] S_ERR  = 4'b1000;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    qos_fc_ctrl_if #(.MW(MW), .VW(VW), .DW(DW)) bus ();

    qos_fc_ctrl #(.MW(MW), .VW(VW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cnt;
        logic       p0;
        logic       act;
    } vec_t;

    vec_t tbl [9];

    // Behavioural reference state.
    int         m_mode;
    int         m_hi [5];
    int         m_lo [5];
    logic [4:0] m_pause;
    logic [4:0] m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs();
        return 32'({bus.pause, bus.error_full, bus.error_out, bus.active_out,
                    bus.idle_out, bus.init_out});
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] p, input logic [4:0] e,
                                       input logic [3:0] st);
        return 32'({p, e, st});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        bus.init             = 1'b0;
        bus.UmbralesMFs_HIGH = '0;
        bus.UmbralesMFs_LOW  = '0;
        bus.UmbralesVCs_HIGH = '0;
        bus.UmbralesVCs_LOW  = '0;
        bus.UmbralesDs_HIGH  = '0;
        bus.UmbralesDs_LOW   = '0;
        bus.Main_cnt         = '0;
        bus.VC0_cnt          = '0;
        bus.VC1_cnt          = '0;
        bus.D0_cnt           = '0;
        bus.D1_cnt           = '0;
        bus.fifo_ovf         = '0;
    endtask

    task automatic std_thr();
        bus.UmbralesMFs_HIGH = 4'd3;
        bus.UmbralesMFs_LOW  = 4'd1;
        bus.UmbralesVCs_HIGH = {16'd15, 16'd15};
        bus.UmbralesVCs_LOW  = {16'd1, 16'd1};
        bus.UmbralesDs_HIGH  = {4'd3, 4'd3};
        bus.UmbralesDs_LOW   = {4'd1, 4'd1};
    endtask

    // One clock of the reference: the rules applied to the inputs seen at this edge.
    task automatic model_step();
        int   c [5];
        int   hin [5];
        int   lin [5];
        int   old;
        bit   busy;
        c[0] = int'(bus.Main_cnt);
        c[1] = int'(bus.VC0_cnt);
        c[2] = int'(bus.VC1_cnt);
        c[3] = int'(bus.D0_cnt);
        c[4] = int'(bus.D1_cnt);
        hin[0] = int'(bus.UmbralesMFs_HIGH);       lin[0] = int'(bus.UmbralesMFs_LOW);
        hin[1] = int'(bus.UmbralesVCs_HIGH[15:0]); lin[1] = int'(bus.UmbralesVCs_LOW[15:0]);
        hin[2] = int'(bus.UmbralesVCs_HIGH[31:16]);lin[2] = int'(bus.UmbralesVCs_LOW[31:16]);
        hin[3] = int'(bus.UmbralesDs_HIGH[3:0]);   lin[3] = int'(bus.UmbralesDs_LOW[3:0]);
        hin[4] = int'(bus.UmbralesDs_HIGH[7:4]);   lin[4] = int'(bus.UmbralesDs_LOW[7:4]);
        busy = 1'b0;
        for (int i = 0; i < 5; i++) if (c[i] != 0) busy = 1'b1;
        old = m_mode;
        if (bus.init) begin
            m_mode  = M_INIT;
            m_hi    = hin;
            m_lo    = lin;
            m_pause = '0;
            m_err   = '0;
        end else begin
            m_err = m_err | bus.fifo_ovf;
            if (old == M_RESET || old == M_INIT) begin
                m_pause = '0;
            end else begin
                for (int i = 0; i < 5; i++) begin
                    if (c[i] >= m_hi[i])      m_pause[i] = 1'b1;
                    else if (c[i] <= m_lo[i]) m_pause[i] = 1'b0;
                end
            end
            if (old == M_INIT) begin
                m_hi = hin;
                m_lo = lin;
            end
            if (bus.fifo_ovf != 5'b0)  m_mode = M_ERROR;
            else if (old == M_RESET)   m_mode = M_INIT;
            else if (old == M_ERROR)   m_mode = M_ERROR;
            else                       m_mode = busy ? M_ACTIVE : M_IDLE;
        end
    endtask

    function automatic logic [31:0] model_obs();
        logic [3:0] st;
        st = {m_mode == M_ERROR, m_mode == M_ACTIVE, m_mode == M_IDLE, m_mode == M_INIT};
        return mk(m_pause, m_err, st);
    endfunction

    function automatic logic [15:0] rand_vc(input int maxv);
        if ($urandom_range(0, 9) == 0) return 16'hFFFF;
        return 16'($urandom_range(0, maxv));
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        tbl[0] = '{4'd0, 1'b0, 1'b0};
        tbl[1] = '{4'd1, 1'b0, 1'b1};
        tbl[2] = '{4'd2, 1'b0, 1'b1};
        tbl[3] = '{4'd3, 1'b1, 1'b1};
        tbl[4] = '{4'd4, 1'b1, 1'b1};
        tbl[5] = '{4'd3, 1'b1, 1'b1};
        tbl[6] = '{4'd2, 1'b1, 1'b1};
        tbl[7] = '{4'd1, 1'b0, 1'b1};
        tbl[8] = '{4'd0, 1'b0, 1'b0};

        // Reset, then the automatic RESET -> INIT -> IDLE walk.
        zero_inputs();
        reset = 1'b1;
        #12;
        check("reset_state", obs(), mk(5'd0, 5'd0, S_NONE));
        reset = 1'b0;
        tick();
        check("first_init", obs(), mk(5'd0, 5'd0, S_INIT));
        tick();
        check("first_idle", obs(), mk(5'd0, 5'd0, S_IDLE));

        // Main hysteresis ramp with H=3/L=1.
        std_thr();
        bus.init = 1'b1;
        tick();
        check("t2_init", obs(), mk(5'd0, 5'd0, S_INIT));
        bus.init = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.Main_cnt = tbl[i].cnt;
            tick();
            check($sformatf("t2_pause[%0d]", i), 32'(bus.pause), 32'({4'b0, tbl[i].p0}));
            check($sformatf("t2_active[%0d]", i), 32'(bus.active_out), 32'(tbl[i].act));
        end

        // D0 at its HIGH threshold; threshold inputs changed outside INIT are ignored.
        bus.D0_cnt = 4'd3;
        tick();
        check("t3_d0_pause", obs(), mk(5'b01000, 5'd0, S_ACT));
        bus.UmbralesDs_HIGH = {4'hF, 4'hF};
        bus.UmbralesDs_LOW  = {4'hE, 4'hE};
        tick();
        tick();
        check("t3_frozen", obs(), mk(5'b01000, 5'd0, S_ACT));

        // Overflows: enter ERROR, accumulate sticky bits, stay there until init.
        bus.fifo_ovf = 5'b01000;
        tick();
        bus.fifo_ovf = 5'b0;
        check("t4_err1", obs(), mk(5'b01000, 5'b01000, S_ERR));
        tick();
        check("t4_err_hold", obs(), mk(5'b01000, 5'b01000, S_ERR));
        bus.fifo_ovf = 5'b00001;
        tick();
        bus.fifo_ovf = 5'b0;
        check("t4_err2", obs(), mk(5'b01000, 5'b01001, S_ERR));
        bus.D0_cnt = 4'd0;
        tick();
        check("t4_empty_err", obs(), mk(5'b00000, 5'b01001, S_ERR));
        bus.init = 1'b1;
        tick();
        check("t4_init_clear", obs(), mk(5'd0, 5'd0, S_INIT));

        // init and an overflow on the same edge: init wins.
        bus.fifo_ovf = 5'b00010;
        tick();
        check("t5_init_wins", obs(), mk(5'd0, 5'd0, S_INIT));
        bus.init     = 1'b0;
        bus.fifo_ovf = 5'b0;
        tick();
        check("t5_idle", obs(), mk(5'd0, 5'd0, S_IDLE));

        // All five pause bits set, then an asynchronous reset between edges.
        std_thr();
        bus.init = 1'b1;
        tick();
        bus.init     = 1'b0;
        bus.Main_cnt = 4'd4;
        bus.VC0_cnt  = 16'd20;
        bus.VC1_cnt  = 16'd15;
        bus.D0_cnt   = 4'd3;
        bus.D1_cnt   = 4'd4;
        tick();
        check("t6_active", obs(), mk(5'd0, 5'd0, S_ACT));
        tick();
        check("t6_pause_all", obs(), mk(5'h1F, 5'd0, S_ACT));
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_reset", obs(), mk(5'd0, 5'd0, S_NONE));

        // Randomized run against the reference model.
        zero_inputs();
        tick();
        check("rand_reset_hold", obs(), mk(5'd0, 5'd0, S_NONE));
        reset   = 1'b0;
        m_mode  = M_RESET;
        m_pause = '0;
        m_err   = '0;
        for (int i = 0; i < 5; i++) begin
            m_hi[i] = 0;
            m_lo[i] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            bus.init             = (n < 3) || ($urandom_range(0, 24) == 0);
            bus.UmbralesMFs_HIGH = 4'($urandom_range(0, 15));
            bus.UmbralesMFs_LOW  = 4'($urandom_range(0, 15));
            bus.UmbralesVCs_HIGH = {rand_vc(20), rand_vc(20)};
            bus.UmbralesVCs_LOW  = {rand_vc(20), rand_vc(20)};
            bus.UmbralesDs_HIGH  = 8'($urandom);
            bus.UmbralesDs_LOW   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus.Main_cnt = '0;
                bus.VC0_cnt  = '0;
                bus.VC1_cnt  = '0;
                bus.D0_cnt   = '0;
                bus.D1_cnt   = '0;
            end else begin
                bus.Main_cnt = 4'($urandom_range(0, 15));
                bus.VC0_cnt  = rand_vc(24);
                bus.VC1_cnt  = rand_vc(24);
                bus.D0_cnt   = 4'($urandom_range(0, 15));
                bus.D1_cnt   = 4'($urandom_range(0, 15));
            end
            bus.fifo_ovf = ($urandom_range(0, 39) == 0) ? 5'($urandom) : 5'b0;
            @(posedge clk);
            model_step();
            #1;
            check("rand", obs(), model_obs());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
